// File: rtl/intersection_sequencer.sv
// Timed eight-phase intersection sequencer: 1 s tick-driven dwell timer, demand-skipped
// protected left phases, and emergency pre-emption into a held all-red.
module intersection_sequencer #(
  parameter int T_GREEN  = 10,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_LEFT   = 5,
  parameter int CW       = 8
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          tick,
  input  logic          emergency,
  input  logic          left_req_ns,
  input  logic          left_req_ew,
  output logic [2:0]    phase,
  output logic [CW-1:0] secs_left,
  output logic          phase_start,
  output logic          emg_hold
);

  typedef enum logic [2:0] {
    P_NSG  = 3'd0,
    P_NSY  = 3'd1,
    P_RED1 = 3'd2,
    P_EWL  = 3'd3,
    P_EWG  = 3'd4,
    P_EWY  = 3'd5,
    P_RED2 = 3'd6,
    P_NSL  = 3'd7
  } phase_e;

  localparam logic [CW-1:0] LD_GRN = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] LD_YEL = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] LD_RED = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] LD_LFT = CW'(T_LEFT - 1);

  phase_e        phase_q, phase_d;
  logic [CW-1:0] secs_q, secs_d;
  logic          pend_ns_q, pend_ns_d;
  logic          pend_ew_q, pend_ew_d;
  logic          phase_start_q, phase_start_d;
  logic          emg_hold_q, emg_hold_d;
  phase_e        nxt;
  logic          is_red;

  function automatic logic [CW-1:0] load_val(input phase_e p);
    case (p)
      P_NSG, P_EWG:  load_val = LD_GRN;
      P_NSY, P_EWY:  load_val = LD_YEL;
      P_RED1, P_RED2: load_val = LD_RED;
      default:       load_val = LD_LFT;
    endcase
  endfunction

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      phase_q       <= P_NSG;
      secs_q        <= LD_GRN;
      pend_ns_q     <= 1'b0;
      pend_ew_q     <= 1'b0;
      phase_start_q <= 1'b0;
      emg_hold_q    <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      secs_q        <= secs_d;
      pend_ns_q     <= pend_ns_d;
      pend_ew_q     <= pend_ew_d;
      phase_start_q <= phase_start_d;
      emg_hold_q    <= emg_hold_d;
    end
  end

  // Next-state: emergency outranks the tick; left phases only on registered demand
  always_comb begin
    nxt = P_NSG;
    case (phase_q)
      P_NSG:   nxt = P_NSY;
      P_NSY:   nxt = P_RED1;
      P_RED1:  nxt = pend_ew_q ? P_EWL : P_EWG;
      P_EWL:   nxt = P_EWG;
      P_EWG:   nxt = P_EWY;
      P_EWY:   nxt = P_RED2;
      P_RED2:  nxt = pend_ns_q ? P_NSL : P_NSG;
      default: nxt = P_NSG;
    endcase

    is_red  = (phase_q == P_RED1) || (phase_q == P_RED2);
    phase_d = phase_q;
    secs_d  = secs_q;
    if (emergency && phase_q == P_NSG) begin
      phase_d = P_NSY;
      secs_d  = LD_YEL;
    end else if (emergency && phase_q == P_EWG) begin
      phase_d = P_EWY;
      secs_d  = LD_YEL;
    end else if (emergency && phase_q == P_EWL) begin
      phase_d = P_RED1;
      secs_d  = LD_RED;
    end else if (emergency && phase_q == P_NSL) begin
      phase_d = P_RED2;
      secs_d  = LD_RED;
    end else if (emergency && is_red) begin
      secs_d  = LD_RED;
    end else if (tick) begin
      if (secs_q != '0) begin
        secs_d = secs_q - CW'(1);
      end else begin
        phase_d = nxt;
        secs_d  = load_val(nxt);
      end
    end

    // Entering the left phase clears its request even if one arrives that cycle
    pend_ew_d = (phase_d == P_EWL && phase_q != P_EWL) ? 1'b0 : (pend_ew_q | left_req_ew);
    pend_ns_d = (phase_d == P_NSL && phase_q != P_NSL) ? 1'b0 : (pend_ns_q | left_req_ns);
  end

  // Output logic
  always_comb begin
    phase_start_d = (phase_d != phase_q);
    emg_hold_d    = emergency && ((phase_d == P_RED1) || (phase_d == P_RED2));
  end

  assign phase       = phase_q;
  assign secs_left   = secs_q;
  assign phase_start = phase_start_q;
  assign emg_hold    = emg_hold_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Directed bench for intersection_sequencer: a per-cycle vector table followed by
// hand-written multi-cycle sequences for demand skipping, pre-emption and reset.
module tb_intersection_sequencer;

  logic       clk;
  logic       reset, tick, emergency, left_req_ns, left_req_ew;
  logic [2:0] phase;
  logic [7:0] secs_left;
  logic       phase_start, emg_hold;

  int n_cmp = 0;
  int n_err = 0;

  intersection_sequencer #(
    .T_GREEN(10), .T_YELLOW(3), .T_ALLRED(2), .T_LEFT(5), .CW(8)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .tick        (tick),
    .emergency   (emergency),
    .left_req_ns (left_req_ns),
    .left_req_ew (left_req_ew),
    .phase       (phase),
    .secs_left   (secs_left),
    .phase_start (phase_start),
    .emg_hold    (emg_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, tk, emg, rns, rew;
    logic [2:0] ph;
    logic [7:0] secs;
    logic       ps, eh;
  } vec_t;

  vec_t tbl[21];

  task automatic cyc(input logic t, input logic rn, input logic re, input logic rs);
    tick = t; left_req_ns = rn; left_req_ew = re; reset = rs;
    @(posedge clk);
    #1;
    tick = 1'b0; left_req_ns = 1'b0; left_req_ew = 1'b0; reset = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [2:0] ep, input logic [7:0] es,
                     input logic eps, input logic eeh);
    n_cmp++;
    if (phase !== ep || secs_left !== es || phase_start !== eps || emg_hold !== eeh) begin
      n_err++;
      $display("FAIL %s: got phase=%0d secs=%0d ps=%b eh=%b, want phase=%0d secs=%0d ps=%b eh=%b",
               nm, phase, secs_left, phase_start, emg_hold, ep, es, eps, eeh);
    end
  endtask

  task automatic do_reset();
    emergency = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_state", 3'd0, 8'd9, 1'b0, 1'b0);
  endtask

  // Walk one phase of length t, checking the countdown every tick
  task automatic run_phase(input string nm, input logic [2:0] p, input int t, input logic first_ps);
    for (int k = 0; k < t; k++) begin
      chk(nm, p, 8'(t - 1 - k), (k == 0) ? first_ps : 1'b0, 1'b0);
      ticks(1);
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; emergency = 1'b0; left_req_ns = 1'b0; left_req_ew = 1'b0;

    //            rst   tk    emg   rns   rew   ph    secs   ps    eh
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd9, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd8, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd7, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd6, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd5, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd4, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd3, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd2, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'd2, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd2, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd2, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 8'd1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'd1, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'd1, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 8'd9, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd9, 1'b0, 1'b0};

    for (int i = 0; i < 21; i++) begin
      emergency = tbl[i].emg;
      cyc(tbl[i].tk, tbl[i].rns, tbl[i].rew, tbl[i].rst);
      chk($sformatf("vec%0d", i), tbl[i].ph, tbl[i].secs, tbl[i].ps, tbl[i].eh);
    end

    // Full cycle with no demand: left phases skipped
    do_reset();
    run_phase("walk_p0", 3'd0, 10, 1'b0);
    run_phase("walk_p1", 3'd1, 3, 1'b1);
    run_phase("walk_p2", 3'd2, 2, 1'b1);
    run_phase("walk_p4", 3'd4, 10, 1'b1);
    run_phase("walk_p5", 3'd5, 3, 1'b1);
    run_phase("walk_p6", 3'd6, 2, 1'b1);
    chk("walk_wrap", 3'd0, 8'd9, 1'b1, 1'b0);

    // EW left demand: one cycle pulse, served once, then cleared
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(15);
    chk("ewl_enter", 3'd3, 8'd4, 1'b1, 1'b0);
    ticks(5);
    chk("ewl_to_4", 3'd4, 8'd9, 1'b1, 1'b0);
    ticks(15);
    chk("ewl_wrap0", 3'd0, 8'd9, 1'b1, 1'b0);
    ticks(15);
    chk("ewl_cleared", 3'd4, 8'd9, 1'b1, 1'b0);

    // Emergency in EW green, long hold, release into NS left
    do_reset();
    ticks(18);
    chk("emg4_pre", 3'd4, 8'd6, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    emergency = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("emg4_yel", 3'd5, 8'd2, 1'b1, 1'b0);
    ticks(2);
    chk("emg4_yel_run", 3'd5, 8'd0, 1'b0, 1'b0);
    ticks(1);
    chk("emg4_red", 3'd6, 8'd1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      ticks(1);
      chk("emg4_hold", 3'd6, 8'd1, 1'b0, 1'b1);
    end
    emergency = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("emg4_drop", 3'd6, 8'd1, 1'b0, 1'b0);
    ticks(1);
    chk("emg4_cnt", 3'd6, 8'd0, 1'b0, 1'b0);
    ticks(1);
    chk("emg4_nsl", 3'd7, 8'd4, 1'b1, 1'b0);
    emergency = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("emg7_red", 3'd6, 8'd1, 1'b1, 1'b1);
    emergency = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(2);
    chk("emg7_to_0", 3'd0, 8'd9, 1'b1, 1'b0);

    // Emergency in EW left: back to red, then on to EW green
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(16);
    chk("emg3_pre", 3'd3, 8'd3, 1'b0, 1'b0);
    emergency = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("emg3_red", 3'd2, 8'd1, 1'b1, 1'b1);
    ticks(5);
    chk("emg3_hold", 3'd2, 8'd1, 1'b0, 1'b1);
    emergency = 1'b0;
    ticks(1);
    chk("emg3_rel", 3'd2, 8'd0, 1'b0, 1'b0);
    ticks(1);
    chk("emg3_to_4", 3'd4, 8'd9, 1'b1, 1'b0);

    // Reset in yellow with NS demand and emergency active
    do_reset();
    ticks(15);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10);
    chk("rst5_pre", 3'd5, 8'd2, 1'b1, 1'b0);
    emergency = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst5_edge", 3'd0, 8'd9, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst5_tick_ign", 3'd0, 8'd9, 1'b0, 1'b0);
    emergency = 1'b0;
    ticks(30);
    chk("rst5_pend_clr", 3'd0, 8'd9, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
